fir_cfg_ctrl: RTL and testbench
===============================

FIR_CFG_CTRL -- requirements
Module: fir_cfg_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 11, number of filter coefficients (H0..H10).
REQ-002 SHALL have parameter CNT_W, default 5, width of the in-flight sample counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port VIN  input  1  upstream sample valid; accepted only when VIN and RDY are both 1.
REQ-006 SHALL have port DIN  input  9  upstream sample, signed.
REQ-007 SHALL have port RDY  output  1  sample acceptance; 1 only in state RUN.
REQ-008 SHALL have port CFG_WE  input  1  coefficient shadow-register write strobe.
REQ-009 SHALL have port CFG_ADDR  input  4  shadow index, 0..10 valid.
REQ-010 SHALL have port CFG_DATA  input  9  coefficient value.
REQ-011 SHALL have port CFG_COMMIT  input  1  request to apply the shadow set to the filter.
REQ-012 SHALL have ports H0..H10  output  9 each  active coefficients driven to the filter.
REQ-013 SHALL have port FIR_VIN  output  1  filter input valid.
REQ-014 SHALL have port FIR_DIN  output  9  filter input sample.
REQ-015 SHALL have port FIR_VOUT  input  1  filter output valid.
REQ-016 SHALL have port FIR_DOUT  input  9  filter output sample.
REQ-017 SHALL have port VOUT  output  1  downstream valid: FIR_VOUT gated by the mask.
REQ-018 SHALL have port DOUT  output  9  downstream sample, equal to FIR_DOUT (combinational).
REQ-019 SHALL have port CFG_BUSY  output  1  1 whenever state is not RUN.
REQ-020 SHALL have port CFG_ERR  output  1  sticky error flag.

Function
REQ-021 SHALL implement the states RUN, DRAIN, SWAP, FLUSH and MASK.
REQ-022 In RUN, on each rising edge: FIR_VIN <= VIN&RDY; FIR_DIN <= DIN if accepted, else 0 (1-cycle latency).
REQ-023 In-flight counter: +1 per FIR_VIN=1 cycle, -1 per FIR_VOUT=1 cycle; both in one cycle leaves it unchanged.
REQ-024 Counter increment at all-ones, or decrement at zero, SHALL saturate and set CFG_ERR.
REQ-025 CFG_WE with CFG_ADDR<=10 SHALL write CFG_DATA to that shadow register, in any state.
REQ-026 CFG_WE with CFG_ADDR>=11 SHALL be ignored and set CFG_ERR.
REQ-027 RUN->DRAIN when CFG_COMMIT=1; a sample accepted in the commit cycle SHALL still be forwarded.
REQ-028 CFG_COMMIT outside RUN SHALL be ignored; no error and no queuing.
REQ-029 DRAIN->SWAP when counter==0 and FIR_VIN==0; FIR_VIN SHALL be 0 throughout DRAIN.
REQ-030 SWAP SHALL last 1 cycle: H0..H10 <= shadow values at the start of the cycle; a same-cycle CFG_WE updates the shadow only.
REQ-031 FLUSH SHALL drive FIR_VIN=1 and FIR_DIN=0 for exactly NTAPS-1 (10) consecutive cycles, then go to MASK.
REQ-032 While in FLUSH or MASK, the first NTAPS-1 FIR_VOUT pulses after SWAP SHALL be suppressed (VOUT=0); MASK->RUN after the 10th.
REQ-033 Outside the suppression window, VOUT SHALL equal FIR_VOUT.
REQ-034 CFG_ERR SHALL be cleared only by reset.

Reset
REQ-035 On RST_n=0, immediately: state RUN; H0..H10, shadow, FIR_DIN, counter, mask count = 0; FIR_VIN=0; CFG_ERR=0; RDY=1; CFG_BUSY=0.
REQ-036 Reset mid-DRAIN, mid-FLUSH or mid-MASK SHALL abort the sequence; the pending shadow set is discarded.

Verification
REQ-037 Reset, write shadow 0..10 = 1..11, commit, no traffic -> DRAIN 1 cycle, SWAP, H0..H10=1..11, 10 FLUSH cycles, RDY=1 after 10 masked outputs.
REQ-038 Stream DIN=100 continuously, commit mid-stream -> RDY=0 until drain completes; every accepted sample appears once on VOUT; zero flush outputs visible.
REQ-039 CFG_WE at ADDR=12 with DATA=5 -> all shadow registers unchanged, CFG_ERR=1 and held until reset.
REQ-040 CFG_WE ADDR=3 DATA=7 in the SWAP cycle -> H3 takes the old shadow value; a second commit gives H3=7.
REQ-041 Assert RST_n=0 during FLUSH cycle 4 -> all outputs return to reset values asynchronously; H0..H10=0.
REQ-042 CFG_COMMIT pulsed during MASK -> ignored; exactly one SWAP occurs.

Source files
------------

// File: rtl/fir_cfg_ctrl.sv
// fir_cfg_ctrl: run-time coefficient controller wrapped around an external FIR filter.
//
// Samples pass from VIN/DIN to FIR_VIN/FIR_DIN through one register stage while in RUN.
// Coefficients are staged in a shadow bank through CFG_WE/CFG_ADDR/CFG_DATA. A
// CFG_COMMIT request drains the filter, copies the shadow bank to H0..H10 in a single
// SWAP cycle, pushes NTAPS-1 zero samples through the filter (FLUSH) and hides the
// first NTAPS-1 filter outputs after the swap, so no output mixes old and new
// coefficients.
//
// Ports
//   CLK, RST_n          clock (rising edge) and asynchronous active-low reset
//   VIN, DIN, RDY       upstream sample handshake; a sample is taken when VIN & RDY
//   CFG_WE/ADDR/DATA    shadow coefficient write port (ADDR 0..NTAPS-1)
//   CFG_COMMIT          apply the shadow bank (honoured only in RUN)
//   H0..H10             active coefficients to the filter
//   FIR_VIN, FIR_DIN    filter input
//   FIR_VOUT, FIR_DOUT  filter output
//   VOUT, DOUT          downstream output, VOUT masked during the post-swap window
//   CFG_BUSY            high whenever not in RUN
//   CFG_ERR             sticky: bad shadow address or in-flight counter over/underflow
//
// H0..H10 are fixed ports, so NTAPS is expected to stay at 11.
module fir_cfg_ctrl #(
  parameter int unsigned NTAPS = 11,
  parameter int unsigned CNT_W = 5
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       VIN,
  input  logic [8:0] DIN,
  output logic       RDY,
  input  logic       CFG_WE,
  input  logic [3:0] CFG_ADDR,
  input  logic [8:0] CFG_DATA,
  input  logic       CFG_COMMIT,
  output logic [8:0] H0,
  output logic [8:0] H1,
  output logic [8:0] H2,
  output logic [8:0] H3,
  output logic [8:0] H4,
  output logic [8:0] H5,
  output logic [8:0] H6,
  output logic [8:0] H7,
  output logic [8:0] H8,
  output logic [8:0] H9,
  output logic [8:0] H10,
  output logic       FIR_VIN,
  output logic [8:0] FIR_DIN,
  input  logic       FIR_VOUT,
  input  logic [8:0] FIR_DOUT,
  output logic       VOUT,
  output logic [8:0] DOUT,
  output logic       CFG_BUSY,
  output logic       CFG_ERR
);

  localparam int unsigned MW = $clog2(NTAPS);
  localparam logic [MW-1:0] LastIdx = MW'(NTAPS - 2);   // last flush cycle / 10th mask pulse
  localparam logic [MW-1:0] MaskDone = MW'(NTAPS - 1);  // all masked pulses seen
  localparam logic [3:0] AddrLim = 4'(NTAPS);

  typedef enum logic [2:0] {StRun, StDrain, StSwap, StFlush, StMask} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_fir_vin, w_fir_vin_nxt;
  logic [8:0]       r_fir_din, w_fir_din_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [MW-1:0]    r_flush_cnt, w_flush_cnt_nxt;
  logic [MW-1:0]    r_mask_cnt, w_mask_cnt_nxt;
  logic [8:0]       r_shadow [NTAPS];
  logic [8:0]       r_h [NTAPS];
  logic             r_err;

  logic w_accept, w_addr_ok, w_cnt_err, w_in_window, w_mask_hit;

  assign RDY       = (r_state == StRun);
  assign CFG_BUSY  = ~RDY;
  assign w_accept  = VIN & RDY;
  assign w_addr_ok = (CFG_ADDR < AddrLim);

  // The suppression window closes once NTAPS-1 post-swap pulses have been swallowed.
  assign w_in_window = ((r_state == StFlush) || (r_state == StMask)) &&
                       (r_mask_cnt != MaskDone);
  assign w_mask_hit  = w_in_window & FIR_VOUT;

  assign VOUT    = FIR_VOUT & ~w_in_window;
  assign DOUT    = FIR_DOUT;
  assign FIR_VIN = r_fir_vin;
  assign FIR_DIN = r_fir_din;
  assign CFG_ERR = r_err;

  assign H0  = r_h[0];
  assign H1  = r_h[1];
  assign H2  = r_h[2];
  assign H3  = r_h[3];
  assign H4  = r_h[4];
  assign H5  = r_h[5];
  assign H6  = r_h[6];
  assign H7  = r_h[7];
  assign H8  = r_h[8];
  assign H9  = r_h[9];
  assign H10 = r_h[10];

  // In-flight counter: samples sent to the filter minus samples returned.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_cnt_err = 1'b0;
    case ({r_fir_vin, FIR_VOUT})
      2'b10: begin
        if (&r_cnt) w_cnt_err = 1'b1;
        else        w_cnt_nxt = r_cnt + 1'b1;
      end
      2'b01: begin
        if (r_cnt == '0) w_cnt_err = 1'b1;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_fir_vin_nxt   = 1'b0;
    w_fir_din_nxt   = '0;
    w_flush_cnt_nxt = r_flush_cnt;
    w_mask_cnt_nxt  = w_mask_hit ? r_mask_cnt + 1'b1 : r_mask_cnt;
    unique case (r_state)
      StRun: begin
        // A sample taken in the commit cycle is still forwarded; DRAIN waits for it.
        w_fir_vin_nxt = w_accept;
        w_fir_din_nxt = w_accept ? DIN : '0;
        if (CFG_COMMIT) w_state_nxt = StDrain;
      end
      StDrain: begin
        if ((r_cnt == '0) && !r_fir_vin) w_state_nxt = StSwap;
      end
      StSwap: begin
        w_state_nxt     = StFlush;
        w_fir_vin_nxt   = 1'b1;
        w_flush_cnt_nxt = '0;
        w_mask_cnt_nxt  = '0;
      end
      StFlush: begin
        if (r_flush_cnt == LastIdx) begin
          w_state_nxt = StMask;
        end else begin
          w_fir_vin_nxt   = 1'b1;
          w_flush_cnt_nxt = r_flush_cnt + 1'b1;
        end
      end
      StMask: begin
        if ((r_mask_cnt == MaskDone) || (w_mask_hit && (r_mask_cnt == LastIdx))) begin
          w_state_nxt = StRun;
        end
      end
      default: w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= StRun;
      r_fir_vin   <= 1'b0;
      r_fir_din   <= '0;
      r_cnt       <= '0;
      r_flush_cnt <= '0;
      r_mask_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fir_vin   <= w_fir_vin_nxt;
      r_fir_din   <= w_fir_din_nxt;
      r_cnt       <= w_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_mask_cnt  <= w_mask_cnt_nxt;
      if ((CFG_WE && !w_addr_ok) || w_cnt_err) r_err <= 1'b1;
    end
  end

  // Shadow and active banks. In SWAP the active bank samples the shadow values held
  // at the start of the cycle, so a same-cycle shadow write lands only in the shadow.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        r_shadow[i] <= '0;
        r_h[i]      <= '0;
      end
    end else begin
      if (CFG_WE && w_addr_ok) r_shadow[CFG_ADDR] <= CFG_DATA;
      if (r_state == StSwap) begin
        for (int i = 0; i < int'(NTAPS); i++) r_h[i] <= r_shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Bench for fir_cfg_ctrl. The filter is modelled as a 3-cycle identity delay line
// (loopback) or driven directly from the stimulus table.
module tb_fir_cfg_ctrl;

  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vin, rdy, cfg_we, cfg_commit, fir_vin, fir_vout, vout, cfg_busy, cfg_err;
  logic [8:0] din, cfg_data, fir_din, fir_dout, dout;
  logic [3:0] cfg_addr;
  logic [8:0] h [11];

  logic         loop_en;
  logic         drv_fvout;
  logic [8:0]   drv_fdout;
  logic [L-1:0] pipe_v;
  logic [8:0]   pipe_d [L];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       vin;
    logic [8:0] din;
    logic       fvout;
    logic [8:0] fdout;
    logic       e_vout;
    logic [8:0] e_dout;
    logic       e_fvin;
    logic [8:0] e_fdin;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  fir_cfg_ctrl dut (
    .CLK(clk), .RST_n(rst_n), .VIN(vin), .DIN(din), .RDY(rdy),
    .CFG_WE(cfg_we), .CFG_ADDR(cfg_addr), .CFG_DATA(cfg_data), .CFG_COMMIT(cfg_commit),
    .H0(h[0]), .H1(h[1]), .H2(h[2]), .H3(h[3]), .H4(h[4]), .H5(h[5]),
    .H6(h[6]), .H7(h[7]), .H8(h[8]), .H9(h[9]), .H10(h[10]),
    .FIR_VIN(fir_vin), .FIR_DIN(fir_din), .FIR_VOUT(fir_vout), .FIR_DOUT(fir_dout),
    .VOUT(vout), .DOUT(dout), .CFG_BUSY(cfg_busy), .CFG_ERR(cfg_err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < L; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[L-2:0], fir_vin};
      pipe_d[0] <= fir_din;
      for (int i = 1; i < L; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign fir_vout = loop_en ? pipe_v[L-1] : drv_fvout;
  assign fir_dout = loop_en ? pipe_d[L-1] : drv_fdout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vin = 0; din = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0; cfg_commit = 0;
    drv_fvout = 0; drv_fdout = '0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [8:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic check_h(input string nm, input int base, input int step);
    for (int i = 0; i < 11; i++) chk(nm, 32'(h[i]), 32'((base + step * i) & 9'h1ff));
  endtask

  task automatic wait_rdy(input string nm);
    for (int c = 0; c < 100 && !rdy; c++) tick();
    chk(nm, 32'(rdy), 32'd1);
  endtask

  task automatic commit_wait(input string nm);
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    chk({nm, "_busy"}, 32'(cfg_busy), 32'd1);
    wait_rdy({nm, "_rdy"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nfl, nfv, nvo, acc, good, bad, saw_busy;

    // vin din fvout fdout | vout dout | fir_vin fir_din (after the edge)
    vecs[0] = '{1'b1, 9'd100, 1'b0, 9'd0,   1'b0, 9'd0,   1'b1, 9'd100};
    vecs[1] = '{1'b0, 9'd55,  1'b1, 9'd100, 1'b1, 9'd100, 1'b0, 9'd0};
    vecs[2] = '{1'b1, 9'h100, 1'b0, 9'd0,   1'b0, 9'd0,   1'b1, 9'h100};
    vecs[3] = '{1'b1, 9'd255, 1'b1, 9'h100, 1'b1, 9'h100, 1'b1, 9'd255};
    vecs[4] = '{1'b0, 9'd7,   1'b1, 9'd255, 1'b1, 9'd255, 1'b0, 9'd0};
    vecs[5] = '{1'b0, 9'd0,   1'b0, 9'd0,   1'b0, 9'd0,   1'b0, 9'd0};

    loop_en = 0;
    do_reset();
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_fir_vin", 32'(fir_vin), 32'd0);
    chk("rst_fir_din", 32'(fir_din), 32'd0);
    check_h("rst_h", 0, 0);

    // Pass-through in RUN.
    for (int i = 0; i < 6; i++) begin
      vin = vecs[i].vin; din = vecs[i].din;
      drv_fvout = vecs[i].fvout; drv_fdout = vecs[i].fdout;
      #1;
      chk($sformatf("vec%0d_vout", i), 32'(vout), 32'(vecs[i].e_vout));
      chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].e_dout));
      chk($sformatf("vec%0d_rdy", i), 32'(rdy), 32'd1);
      tick();
      chk($sformatf("vec%0d_fir_vin", i), 32'(fir_vin), 32'(vecs[i].e_fvin));
      chk($sformatf("vec%0d_fir_din", i), 32'(fir_din), 32'(vecs[i].e_fdin));
    end
    chk("vec_err", 32'(cfg_err), 32'd0);

    // Idle commit: 1-cycle DRAIN, SWAP, 10 FLUSH cycles, 10 masked outputs.
    loop_en = 1;
    do_reset();
    for (int i = 0; i < 11; i++) wr(4'(i), 9'(i + 1));
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    chk("idle_drain_rdy", 32'(rdy), 32'd0);
    chk("idle_drain_busy", 32'(cfg_busy), 32'd1);
    tick();
    chk("idle_swap_h0_old", 32'(h[0]), 32'd0);
    chk("idle_swap_fir_vin", 32'(fir_vin), 32'd0);
    tick();
    check_h("idle_h", 1, 1);
    nfl = 0; nfv = 0; nvo = 0;
    for (int c = 0; c < 60 && !rdy; c++) begin
      if (fir_vin) begin
        nfl++;
        chk("idle_flush_din", 32'(fir_din), 32'd0);
      end
      if (fir_vout) nfv++;
      if (vout) nvo++;
      tick();
    end
    chk("idle_rdy_back", 32'(rdy), 32'd1);
    chk("idle_flush_cycles", 32'(nfl), 32'd10);
    chk("idle_fir_vout_cnt", 32'(nfv), 32'd10);
    chk("idle_vout_cnt", 32'(nvo), 32'd0);
    chk("idle_err", 32'(cfg_err), 32'd0);

    // Continuous stream with a commit mid-stream.
    do_reset();
    acc = 0; good = 0; bad = 0; saw_busy = 0;
    for (int c = 0; c < 90; c++) begin
      cfg_commit = (c == 5);
      vin = (c < 60);
      din = 9'd100;
      if (vin && rdy) acc++;
      if (vout) begin
        if (dout == 9'd100) good++;
        else bad++;
      end
      if (!rdy) saw_busy = 1;
      tick();
    end
    cfg_commit = 0;
    vin = 0;
    chk("stream_saw_busy", 32'(saw_busy), 32'd1);
    chk("stream_once_each", 32'(good), 32'(acc));
    chk("stream_flush_hidden", 32'(bad), 32'd0);
    chk("stream_rdy_end", 32'(rdy), 32'd1);
    chk("stream_err", 32'(cfg_err), 32'd0);

    // Out-of-range shadow address.
    do_reset();
    for (int i = 0; i < 11; i++) wr(4'(i), 9'(20 + i));
    chk("badaddr_err_before", 32'(cfg_err), 32'd0);
    wr(4'd12, 9'd5);
    chk("badaddr_err", 32'(cfg_err), 32'd1);
    commit_wait("badaddr_commit");
    check_h("badaddr_h", 20, 1);
    for (int c = 0; c < 5; c++) tick();
    chk("badaddr_err_held", 32'(cfg_err), 32'd1);

    // Shadow write in the SWAP cycle.
    do_reset();
    wr(4'd3, 9'd9);
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    tick();
    chk("swapwr_in_swap", 32'(rdy), 32'd0);
    cfg_we = 1; cfg_addr = 4'd3; cfg_data = 9'd7;
    tick();
    cfg_we = 0;
    chk("swapwr_h3_old", 32'(h[3]), 32'd9);
    wait_rdy("swapwr_rdy1");
    commit_wait("swapwr_commit2");
    chk("swapwr_h3_new", 32'(h[3]), 32'd7);
    chk("swapwr_err", 32'(cfg_err), 32'd0);

    // Reset during FLUSH cycle 4.
    do_reset();
    for (int i = 0; i < 11; i++) wr(4'(i), 9'(i + 1));
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    for (int c = 0; c < 5; c++) tick();
    chk("rstflush_in_flush", 32'(fir_vin), 32'd1);
    chk("rstflush_h1", 32'(h[1]), 32'd2);
    rst_n = 0;
    #1;
    check_h("rstflush_h", 0, 0);
    chk("rstflush_fir_vin", 32'(fir_vin), 32'd0);
    chk("rstflush_fir_din", 32'(fir_din), 32'd0);
    chk("rstflush_rdy", 32'(rdy), 32'd1);
    chk("rstflush_busy", 32'(cfg_busy), 32'd0);
    chk("rstflush_vout", 32'(vout), 32'd0);
    rst_n = 1;
    tick();
    commit_wait("rstflush_recommit");
    check_h("rstflush_shadow_gone", 0, 0);

    // Commit during MASK is ignored.
    do_reset();
    for (int i = 0; i < 11; i++) wr(4'(i), 9'(i + 1));
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    nfl = 0;
    for (int c = 0; c < 80; c++) begin
      if (c == 14) begin
        chk("maskcommit_busy", 32'(cfg_busy), 32'd1);
        chk("maskcommit_no_fir_vin", 32'(fir_vin), 32'd0);
      end
      cfg_commit = (c == 14);
      if (fir_vin) nfl++;
      tick();
    end
    cfg_commit = 0;
    chk("maskcommit_one_swap", 32'(nfl), 32'd10);
    chk("maskcommit_rdy", 32'(rdy), 32'd1);
    chk("maskcommit_err", 32'(cfg_err), 32'd0);
    check_h("maskcommit_h", 1, 1);

    // Filter output with nothing in flight underflows the counter.
    loop_en = 0;
    do_reset();
    drv_fvout = 1;
    tick();
    drv_fvout = 0;
    chk("underflow_err", 32'(cfg_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
